// File: rtl/dco_bank_ctrl_pkg.sv
// Shared types and helpers for the DCO capacitor-bank controller.
package dco_bank_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SLEW   = 2'd1,
    SETTLE = 2'd2
  } state_e;

  // Bits needed to hold any count in 0..n inclusive.
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic int unsigned clamp(input int unsigned value, input int unsigned limit);
    return (value > limit) ? limit : value;
  endfunction

endpackage

// File: rtl/dco_bank_ctrl_if.sv
// Tuning-word handshake between the loop filter (master) and the bank controller (slave).
// A word transfers on the rising clk edge where otw_valid and otw_ready are both high;
// otw_valid while otw_ready is low is dropped, and the master may change the word freely then.
interface dco_bank_ctrl_if
  import dco_bank_ctrl_pkg::*;
#(
  parameter int LW     = cnt_w(5 * 5),
  parameter int MW     = cnt_w(16 * 16),
  parameter int SW     = cnt_w(16 * 16),
  parameter int FRAC_W = 6
);
  logic              otw_valid;
  logic              otw_ready;
  logic [LW-1:0]     otw_l;
  logic [MW-1:0]     otw_m;
  logic [SW-1:0]     otw_s;
  logic [FRAC_W-1:0] otw_frac;

  modport master (output otw_valid, otw_l, otw_m, otw_s, otw_frac, input otw_ready);
  modport slave  (input otw_valid, otw_l, otw_m, otw_s, otw_frac, output otw_ready);
endinterface

// File: rtl/dco_bank_ctrl_therm_rc_enc.sv
// Combinational count -> row-all / row / column encoder for one ROWS x COLS bank.
module therm_rc_enc
  import dco_bank_ctrl_pkg::*;
#(
  parameter int ROWS = 16,
  parameter int COLS = 16,
  parameter int CW   = cnt_w(ROWS * COLS)
) (
  input  logic [CW-1:0]   cnt_i,
  output logic [ROWS-1:0] rall_o,
  output logic [ROWS-1:0] row_o,
  output logic [COLS-1:0] col_o
);
  logic [CW-1:0] full_rows;
  logic [CW-1:0] partial;

  assign full_rows = cnt_i / CW'(COLS);
  assign partial   = cnt_i % CW'(COLS);

  // Full rows are driven by row-all; the single partial row uses row & col.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    assign rall_o[r] = (full_rows > CW'(r));
    assign row_o[r]  = (full_rows == CW'(r)) && (partial != '0);
  end

  for (genvar c = 0; c < COLS; c++) begin : g_col
    assign col_o[c] = (partial > CW'(c));
  end
endmodule

// File: rtl/dco_bank_ctrl.sv
// DCO cap-bank controller: clamps tuning words, slew-limits the medium bank, registers bank codes.
// Optional macro DCO_BANK_SD_DITHER_EN adds first-order sigma-delta dither on the small bank.
module dco_bank_ctrl
  import dco_bank_ctrl_pkg::*;
#(
  parameter int L_ROWS     = 5,
  parameter int L_COLS     = 5,
  parameter int M_ROWS     = 16,
  parameter int M_COLS     = 16,
  parameter int S_ROWS     = 16,
  parameter int S_COLS     = 16,
  parameter int FRAC_W     = 6,
  parameter int MAX_STEP_M = 16,
  parameter int SETTLE_CYC = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pd_i,
  dco_bank_ctrl_if.slave    otw,
  output logic [L_ROWS-1:0] c_l_rall_o,
  output logic [L_ROWS-1:0] c_l_row_o,
  output logic [L_COLS-1:0] c_l_col_o,
  output logic [M_ROWS-1:0] c_m_rall_o,
  output logic [M_ROWS-1:0] c_m_row_o,
  output logic [M_COLS-1:0] c_m_col_o,
  output logic [S_ROWS-1:0] c_s_rall_o,
  output logic [S_ROWS-1:0] c_s_row_o,
  output logic [S_COLS-1:0] c_s_col_o,
  output logic              busy_o,
  output logic              settled_o,
  output state_e            dbg_state_o
);
  localparam int L_MAX  = L_ROWS * L_COLS;
  localparam int M_MAX  = M_ROWS * M_COLS;
  localparam int S_MAX  = S_ROWS * S_COLS;
  localparam int LW     = cnt_w(L_MAX);
  localparam int MW     = cnt_w(M_MAX);
  localparam int SW     = cnt_w(S_MAX);
  localparam int CW     = cnt_w(SETTLE_CYC);
  localparam int STEP_I = (MAX_STEP_M > M_MAX) ? M_MAX : MAX_STEP_M;
  localparam logic [MW-1:0] STEP     = MW'(STEP_I);
  localparam logic [CW-1:0] CNT_INIT = CW'(SETTLE_CYC - 1);

  state_e        state_q, state_d;
  logic [LW-1:0] cur_l_q, cur_l_d;
  logic [MW-1:0] cur_m_q, cur_m_d, tgt_m_q, tgt_m_d;
  logic [SW-1:0] cur_s_q, cur_s_d, s_cnt;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          settled_q, settled_d;

  logic [LW-1:0] l_clamp;
  logic [MW-1:0] m_clamp, m_diff, m_next;
  logic [SW-1:0] s_clamp;

  assign l_clamp = LW'(clamp(32'(otw.otw_l), L_MAX));
  assign m_clamp = MW'(clamp(32'(otw.otw_m), M_MAX));
  assign s_clamp = SW'(clamp(32'(otw.otw_s), S_MAX));

  assign otw.otw_ready = (state_q == IDLE) && !pd_i;
  assign busy_o        = (state_q != IDLE);
  assign settled_o     = settled_q;
  assign dbg_state_o   = state_q;

  // Medium-bank step toward the target, limited to STEP cells per cycle.
  always_comb begin
    m_diff = (tgt_m_q > cur_m_q) ? (tgt_m_q - cur_m_q) : (cur_m_q - tgt_m_q);
    if (m_diff <= STEP)           m_next = tgt_m_q;
    else if (tgt_m_q > cur_m_q)   m_next = cur_m_q + STEP;
    else                          m_next = cur_m_q - STEP;
  end

  always_comb begin
    state_d   = state_q;
    cur_l_d   = cur_l_q;
    cur_m_d   = cur_m_q;
    cur_s_d   = cur_s_q;
    tgt_m_d   = tgt_m_q;
    cnt_d     = cnt_q;
    settled_d = settled_q;
    if (pd_i) begin
      state_d   = IDLE;
      settled_d = 1'b0;
      tgt_m_d   = cur_m_q;
    end else begin
      case (state_q)
        IDLE: begin
          if (otw.otw_valid) begin
            cur_l_d   = l_clamp;
            cur_s_d   = s_clamp;
            tgt_m_d   = m_clamp;
            settled_d = 1'b0;
            if (m_clamp == cur_m_q) begin
              state_d = SETTLE;
              cnt_d   = CNT_INIT;
            end else begin
              state_d = SLEW;
            end
          end
        end
        SLEW: begin
          cur_m_d = m_next;
          if (m_next == tgt_m_q) begin
            state_d = SETTLE;
            cnt_d   = CNT_INIT;
          end
        end
        SETTLE: begin
          if (cnt_q == '0) begin
            state_d   = IDLE;
            settled_d = 1'b1;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

`ifdef DCO_BANK_SD_DITHER_EN
  logic [FRAC_W-1:0] acc_q, acc_d;
  logic [FRAC_W:0]   acc_sum;

  // The carry is suppressed in power-down so the small bank holds its base count.
  always_comb begin
    acc_sum = {1'b0, acc_q} + {1'b0, otw.otw_frac};
    acc_d   = pd_i ? acc_q : acc_sum[FRAC_W-1:0];
    s_cnt   = (acc_sum[FRAC_W] && !pd_i && (cur_s_q != SW'(S_MAX))) ? cur_s_q + SW'(1) : cur_s_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
  end
`else
  logic unused_frac;
  assign unused_frac = ^otw.otw_frac;
  assign s_cnt       = cur_s_q;
`endif

  logic [L_ROWS-1:0] l_rall_e, l_row_e;
  logic [L_COLS-1:0] l_col_e;
  logic [M_ROWS-1:0] m_rall_e, m_row_e;
  logic [M_COLS-1:0] m_col_e;
  logic [S_ROWS-1:0] s_rall_e, s_row_e;
  logic [S_COLS-1:0] s_col_e;

  therm_rc_enc #(.ROWS(L_ROWS), .COLS(L_COLS)) u_enc_l (
    .cnt_i(cur_l_q), .rall_o(l_rall_e), .row_o(l_row_e), .col_o(l_col_e));
  therm_rc_enc #(.ROWS(M_ROWS), .COLS(M_COLS)) u_enc_m (
    .cnt_i(cur_m_q), .rall_o(m_rall_e), .row_o(m_row_e), .col_o(m_col_e));
  therm_rc_enc #(.ROWS(S_ROWS), .COLS(S_COLS)) u_enc_s (
    .cnt_i(s_cnt), .rall_o(s_rall_e), .row_o(s_row_e), .col_o(s_col_e));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cur_l_q    <= '0;
      cur_m_q    <= '0;
      cur_s_q    <= '0;
      tgt_m_q    <= '0;
      cnt_q      <= '0;
      settled_q  <= 1'b0;
      c_l_rall_o <= '0;
      c_l_row_o  <= '0;
      c_l_col_o  <= '0;
      c_m_rall_o <= '0;
      c_m_row_o  <= '0;
      c_m_col_o  <= '0;
      c_s_rall_o <= '0;
      c_s_row_o  <= '0;
      c_s_col_o  <= '0;
    end else begin
      state_q    <= state_d;
      cur_l_q    <= cur_l_d;
      cur_m_q    <= cur_m_d;
      cur_s_q    <= cur_s_d;
      tgt_m_q    <= tgt_m_d;
      cnt_q      <= cnt_d;
      settled_q  <= settled_d;
      c_l_rall_o <= l_rall_e;
      c_l_row_o  <= l_row_e;
      c_l_col_o  <= l_col_e;
      c_m_rall_o <= m_rall_e;
      c_m_row_o  <= m_row_e;
      c_m_col_o  <= m_col_e;
      c_s_rall_o <= s_rall_e;
      c_s_row_o  <= s_row_e;
      c_s_col_o  <= s_col_e;
    end
  end
endmodule

// File: tb/tb_dco_bank_ctrl.sv
// Directed self-checking bench for dco_bank_ctrl (default geometry 5x5 / 16x16 / 16x16).
module tb_dco_bank_ctrl;
  import dco_bank_ctrl_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        pd;
  logic [4:0]  c_l_rall, c_l_row, c_l_col;
  logic [15:0] c_m_rall, c_m_row, c_m_col;
  logic [15:0] c_s_rall, c_s_row, c_s_col;
  logic        busy, settled;
  state_e      dbg_state;

  int checks = 0;
  int errors = 0;

  dco_bank_ctrl_if ifc ();

  dco_bank_ctrl dut (
    .clk(clk), .rst_n(rst_n), .pd_i(pd), .otw(ifc.slave),
    .c_l_rall_o(c_l_rall), .c_l_row_o(c_l_row), .c_l_col_o(c_l_col),
    .c_m_rall_o(c_m_rall), .c_m_row_o(c_m_row), .c_m_col_o(c_m_col),
    .c_s_rall_o(c_s_rall), .c_s_row_o(c_s_row), .c_s_col_o(c_s_col),
    .busy_o(busy), .settled_o(settled), .dbg_state_o(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Cells on = count of (r,c) with rall[r] | (row[r] & col[c]).
  function automatic int cells(input logic [15:0] rall, input logic [15:0] row,
                               input logic [15:0] col, input int r_n, input int c_n);
    int n = 0;
    for (int r = 0; r < r_n; r++)
      for (int c = 0; c < c_n; c++)
        if (rall[r] || (row[r] && col[c])) n++;
    return n;
  endfunction

  function automatic int m_cells();
    return cells(c_m_rall, c_m_row, c_m_col, 16, 16);
  endfunction

  function automatic int s_cells();
    return cells(c_s_rall, c_s_row, c_s_col, 16, 16);
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int l, input int m, input int s);
    int n = 0;
    while (!ifc.otw_ready && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (ifc.otw_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_ready: otw_ready=%b required 1", ifc.otw_ready);
    end
    ifc.otw_l     = 5'(l);
    ifc.otw_m     = 9'(m);
    ifc.otw_s     = 9'(s);
    ifc.otw_valid = 1'b1;
    tick();
    ifc.otw_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL wait_idle: busy=%b required 0 after %0d cycles", busy, n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({c_l_rall, c_l_row, c_l_col, c_m_rall, c_m_row, c_m_col, c_s_rall, c_s_row, c_s_col} !== '0) begin
      errors++;
      $display("FAIL reset_codes: bank outputs not all zero");
    end
    checks++;
    if ({ifc.otw_ready, busy, settled} !== 3'b100) begin
      errors++;
      $display("FAIL reset_flags: ready/busy/settled=%b required 100", {ifc.otw_ready, busy, settled});
    end
    #2 rst_n = 1'b1;
    tick();
    checks++;
    if ({c_l_rall, c_m_rall, c_s_rall, ifc.otw_ready, busy, settled} !== {37'd0, 3'b100}) begin
      errors++;
      $display("FAIL reset_release: outputs changed after release");
    end
  endtask

  task automatic test_encoding();
    send(13, 0, 0);
    tick();
    checks++;
    if ({c_l_rall, c_l_row, c_l_col} !== {5'b00011, 5'b00100, 5'b00111}) begin
      errors++;
      $display("FAIL enc_l13: rall=%b row=%b col=%b required 00011 00100 00111", c_l_rall, c_l_row, c_l_col);
    end
    wait_idle();
    send(25, 0, 0);
    tick();
    checks++;
    if ({c_l_rall, c_l_row, c_l_col} !== {5'b11111, 5'b00000, 5'b00000}) begin
      errors++;
      $display("FAIL enc_l25: rall=%b row=%b col=%b required 11111 00000 00000", c_l_rall, c_l_row, c_l_col);
    end
    wait_idle();
    send(0, 0, 0);
    tick();
    checks++;
    if ({c_l_rall, c_l_row, c_l_col} !== 15'd0) begin
      errors++;
      $display("FAIL enc_l0: rall=%b row=%b col=%b required all 0", c_l_rall, c_l_row, c_l_col);
    end
    wait_idle();
  endtask

  task automatic test_slew();
    int exp_m;
    send(0, 200, 0);
    for (int k = 1; k <= 17; k++) begin
      if (k == 3) begin
        checks++;
        if (ifc.otw_ready !== 1'b0) begin
          errors++;
          $display("FAIL slew_ready: otw_ready=%b required 0 during SLEW", ifc.otw_ready);
        end
        ifc.otw_m     = 9'd50;
        ifc.otw_valid = 1'b1;
      end
      tick();
      ifc.otw_valid = 1'b0;
      exp_m = (16 * (k - 1) > 200) ? 200 : 16 * (k - 1);
      if (k <= 14) begin
        checks++;
        if (m_cells() !== exp_m) begin
          errors++;
          $display("FAIL slew_step%0d: medium cells=%0d required %0d", k, m_cells(), exp_m);
        end
      end
      if (k <= 16) begin
        checks++;
        if (busy !== 1'b1) begin
          errors++;
          $display("FAIL slew_busy%0d: busy=%b required 1", k, busy);
        end
      end
      if (k == 16) begin
        checks++;
        if (settled !== 1'b0) begin
          errors++;
          $display("FAIL settle_early: settled=%b required 0", settled);
        end
      end
    end
    checks++;
    if ({busy, settled, ifc.otw_ready} !== 3'b011) begin
      errors++;
      $display("FAIL settle_done: busy/settled/ready=%b required 011", {busy, settled, ifc.otw_ready});
    end
    repeat (3) tick();
    checks++;
    if ({c_m_rall, c_m_row, c_m_col} !== {16'h0FFF, 16'h1000, 16'h00FF}) begin
      errors++;
      $display("FAIL slew_final: rall=%h row=%h col=%h required 0fff 1000 00ff", c_m_rall, c_m_row, c_m_col);
    end
  endtask

  task automatic test_clamp();
    send(0, 300, 511);
    wait_idle();
    tick();
    checks++;
    if ({c_m_rall, c_m_row, c_m_col} !== {16'hFFFF, 16'h0000, 16'h0000}) begin
      errors++;
      $display("FAIL clamp_m: rall=%h row=%h col=%h required ffff 0000 0000", c_m_rall, c_m_row, c_m_col);
    end
    checks++;
    if ({c_s_rall, c_s_row, c_s_col} !== {16'hFFFF, 16'h0000, 16'h0000}) begin
      errors++;
      $display("FAIL clamp_s: rall=%h row=%h col=%h required ffff 0000 0000", c_s_rall, c_s_row, c_s_col);
    end
  endtask

  task automatic test_pd();
    send(0, 0, 0);
    wait_idle();
    send(0, 200, 0);
    repeat (4) tick();
    checks++;
    if (m_cells() !== 48) begin
      errors++;
      $display("FAIL pd_pre: medium cells=%0d required 48", m_cells());
    end
    pd = 1'b1;
    tick();
    checks++;
    if (m_cells() !== 64) begin
      errors++;
      $display("FAIL pd_hold: medium cells=%0d required 64", m_cells());
    end
    checks++;
    if ({ifc.otw_ready, settled, busy} !== 3'b000) begin
      errors++;
      $display("FAIL pd_flags: ready/settled/busy=%b required 000", {ifc.otw_ready, settled, busy});
    end
    repeat (2) tick();
    checks++;
    if (m_cells() !== 64 || dbg_state !== IDLE) begin
      errors++;
      $display("FAIL pd_hold2: medium cells=%0d state=%0d required 64 IDLE", m_cells(), dbg_state);
    end
    pd = 1'b0;
    tick();
    checks++;
    if ({ifc.otw_ready, busy} !== 2'b10 || m_cells() !== 64) begin
      errors++;
      $display("FAIL pd_release: ready/busy=%b cells=%0d required 10 64", {ifc.otw_ready, busy}, m_cells());
    end
  endtask

  task automatic test_dither();
    int highs = 0;
    int exp_highs;
`ifdef DCO_BANK_SD_DITHER_EN
    exp_highs = 32;
`else
    exp_highs = 0;
`endif
    ifc.otw_frac = 6'd32;
    send(0, 64, 10);
    wait_idle();
    for (int k = 0; k < 64; k++) begin
      tick();
      if (s_cells() == 11) highs++;
      checks++;
      if (s_cells() != 10 && !(exp_highs > 0 && s_cells() == 11)) begin
        errors++;
        $display("FAIL dither_range%0d: small cells=%0d required 10%s", k, s_cells(),
                 (exp_highs > 0) ? " or 11" : "");
      end
    end
    checks++;
    if (highs !== exp_highs) begin
      errors++;
      $display("FAIL dither_count: increments=%0d required %0d", highs, exp_highs);
    end
    ifc.otw_frac = '0;
  endtask

  initial begin
    pd            = 1'b0;
    ifc.otw_valid = 1'b0;
    ifc.otw_l     = '0;
    ifc.otw_m     = '0;
    ifc.otw_s     = '0;
    ifc.otw_frac  = '0;
    test_reset();
    test_encoding();
    test_slew();
    test_clamp();
    test_pd();
    test_dither();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
